// File: rtl/fetch_pkg.sv
// Shared types and constants for the DLX fetch stage.
// Optional feature macro used by the top: FETCH_PERF_CNT_EN.
package fetch_pkg;

   localparam int PC_W   = 32;
   localparam int IR_W   = 32;
   localparam int PC_INC = 4;

   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [IR_W-1:0] ir;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-two depth, pointers wrap naturally, flush wins over push.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 64,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  logic [W-1:0]  din_i,
   output logic [W-1:0]  dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_q];

   // A same-cycle pop is simply absorbed by the flush that follows it.
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/fetch_stage.sv
// DLX fetch stage: PC, IMEM req/ack, prefetch FIFO, redirect with flush.
// Define FETCH_PERF_CNT_EN to add the FETCH_CNT/FLUSH_CNT performance counters.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int                PC_SIZE      = 32,
   parameter int                IR_SIZE      = 32,
   parameter int                OP_CODE_SIZE = 6,
   parameter int                FUNC_SIZE    = 11,
   parameter int                FIFO_DEPTH   = 2,
   parameter logic [PC_SIZE-1:0] RESET_PC    = '0
) (
   input  logic                    CLK,
   input  logic                    RST,
   output logic                    IMEM_REQ,
   output logic [PC_SIZE-1:0]      IMEM_ADDR,
   input  logic                    IMEM_ACK,
   input  logic [IR_SIZE-1:0]      IMEM_DATA,
   input  logic                    BR_TAKEN,
   input  logic [PC_SIZE-1:0]      BR_TARGET,
   output logic                    IR_VALID,
   input  logic                    IR_READY,
   output logic [IR_SIZE-1:0]      IR,
   output logic [PC_SIZE-1:0]      NPC,
   output logic [OP_CODE_SIZE-1:0] OPCODE,
   output logic [FUNC_SIZE-1:0]    FUNC,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]             FETCH_CNT,
   output logic [31:0]             FLUSH_CNT,
`endif
   output fetch_state_t            DBG_STATE
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = PC_SIZE + IR_SIZE;

   fetch_state_t        state_q, state_d;
   logic [PC_SIZE-1:0]  pc_q, pc_d, tgt_q, tgt_d, br_pc, head_pc;
   logic                req_q, req_d;
   logic                push, pop, full, empty, room;
   logic [CW-1:0]       count;
   logic [EW-1:0]       head;

   assign br_pc = BR_TARGET & ~(PC_SIZE'(PC_INC - 1));
   assign pop   = IR_VALID && IR_READY;
   assign room  = !full || pop || BR_TAKEN;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      req_d   = req_q;
      push    = 1'b0;
      case (state_q)
         FETCH: begin
            if (req_q) begin
               // REQ drops for one cycle after every ACK.
               if (IMEM_ACK) begin
                  req_d = 1'b0;
                  if (BR_TAKEN) begin
                     pc_d = br_pc;
                  end else begin
                     push = 1'b1;
                     pc_d = pc_q + PC_SIZE'(PC_INC);
                  end
               end else if (BR_TAKEN) begin
                  state_d = DRAIN;
                  tgt_d   = br_pc;
               end
            end else begin
               if (BR_TAKEN) pc_d = br_pc;
               req_d = room;
            end
         end
         DRAIN: begin
            if (BR_TAKEN) tgt_d = br_pc;
            if (IMEM_ACK) begin
               req_d   = 1'b0;
               state_d = FETCH;
               pc_d    = BR_TAKEN ? br_pc : tgt_q;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         tgt_q   <= RESET_PC;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         req_q   <= req_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (BR_TAKEN),
      .din_i   ({pc_q, IMEM_DATA}),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   assign IMEM_REQ  = req_q;
   assign IMEM_ADDR = pc_q;
   assign DBG_STATE = state_q;
   assign IR_VALID  = (count != '0);
   assign head_pc   = head[EW-1 -: PC_SIZE];
   assign IR        = empty ? '0 : head[IR_SIZE-1:0];
   assign NPC       = empty ? '0 : head_pc + PC_SIZE'(PC_INC);
   assign OPCODE    = IR[IR_SIZE-1 -: OP_CODE_SIZE];
   assign FUNC      = IR[FUNC_SIZE-1:0];

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, flush_cnt_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (push && fetch_cnt_q != '1)     fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (BR_TAKEN && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign FETCH_CNT = fetch_cnt_q;
   assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; a second instance uses RESET_PC=0xFFFF_FFFC for the wrap case.
module tb_fetch_stage;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_data = '0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = '0;
   logic        ir_ready = 1'b0;

   logic        a_req, a_valid, b_req, b_valid;
   logic [31:0] a_addr, a_ir, a_npc, b_addr, b_ir, b_npc;
   logic [5:0]  a_opcode, b_opcode;
   logic [10:0] a_func, b_func;
   fetch_state_t a_state, b_state;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] a_fetch_cnt, a_flush_cnt, b_fetch_cnt, b_flush_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int ack_delay = 1;
   int wait_cnt  = 0;
   int n_acks = 0, n_drop = 0, n_br = 0, pops = 0;
   int p0, a0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   fetch_stage u_a (
      .CLK(clk), .RST(rst), .IMEM_REQ(a_req), .IMEM_ADDR(a_addr), .IMEM_ACK(imem_ack),
      .IMEM_DATA(imem_data), .BR_TAKEN(br_taken), .BR_TARGET(br_target), .IR_VALID(a_valid),
      .IR_READY(ir_ready), .IR(a_ir), .NPC(a_npc), .OPCODE(a_opcode), .FUNC(a_func),
`ifdef FETCH_PERF_CNT_EN
      .FETCH_CNT(a_fetch_cnt), .FLUSH_CNT(a_flush_cnt),
`endif
      .DBG_STATE(a_state)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_b (
      .CLK(clk), .RST(rst), .IMEM_REQ(b_req), .IMEM_ADDR(b_addr), .IMEM_ACK(imem_ack),
      .IMEM_DATA(imem_data), .BR_TAKEN(br_taken), .BR_TARGET(br_target), .IR_VALID(b_valid),
      .IR_READY(ir_ready), .IR(b_ir), .NPC(b_npc), .OPCODE(b_opcode), .FUNC(b_func),
`ifdef FETCH_PERF_CNT_EN
      .FETCH_CNT(b_fetch_cnt), .FLUSH_CNT(b_flush_cnt),
`endif
      .DBG_STATE(b_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic load_exp(input logic [31:0] base);
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
   endtask

   // One clock: IMEM responder, pop scoreboard, then advance to just after the next edge.
   task automatic cycle();
      logic [31:0] pc, ir_e;
      imem_ack = 1'b0;
      if (a_req) begin
         wait_cnt++;
         if (wait_cnt >= ack_delay) begin
            imem_ack  = 1'b1;
            imem_data = a_addr | 32'hA000_0000;
            wait_cnt  = 0;
            n_acks++;
         end
      end
      if (br_taken) n_br++;
      if (a_valid && ir_ready) begin
         if (exp_q.size() == 0) begin
            check("pop_unexpected", 32'(a_valid), 32'd0);
         end else begin
            pc   = exp_q.pop_front();
            ir_e = pc | 32'hA000_0000;
            check("pop_ir", a_ir, ir_e);
            check("pop_npc", a_npc, pc + 32'd4);
            check("pop_opcode", 32'(a_opcode), 32'(ir_e[31:26]));
            check("pop_func", 32'(a_func), 32'(ir_e[10:0]));
            pops++;
         end
      end
      @(posedge clk);
      #1;
      br_taken = 1'b0;
   endtask

   task automatic wait_req(input string tag, input logic level);
      int n = 0;
      while (a_req !== level && n < 50) begin
         cycle();
         n++;
      end
      check(tag, 32'(a_req), 32'(level));
   endtask

   initial begin
      #3;
      check("rst_req", 32'(a_req), 32'd0);
      check("rst_valid", 32'(a_valid), 32'd0);
      check("rst_ir", a_ir, 32'd0);
      check("rst_npc", a_npc, 32'd0);
      check("rst_addr", a_addr, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      ir_ready = 1'b1;
      load_exp(32'h0);

      // 1: streaming fetch with one-cycle ack
      wait_req("t1_req0", 1'b1);
      check("t1_addr0", a_addr, 32'h0);
      cycle();
      check("t1_latency", 32'(a_valid), 32'd1);
      check("t1_opcode", 32'(a_opcode), 32'h28);
      check("t1_npc", a_npc, 32'h4);
      wait_req("t1_req1", 1'b1);
      check("t1_addr1", a_addr, 32'h4);
      cycle();
      wait_req("t1_req2", 1'b1);
      check("t1_addr2", a_addr, 32'h8);
      repeat (8) cycle();
      check("t1_pops", 32'(pops >= 4), 32'd1);

      // 2: consumer stalls; exactly two pushes then REQ idles
      begin
         int n = 0;
         while (a_valid && n < 20) begin cycle(); n++; end
      end
      ir_ready = 1'b0;
      a0 = n_acks;
      repeat (10) cycle();
      check("t2_pushes", 32'(n_acks - a0), 32'd2);
      check("t2_req_idle", 32'(a_req), 32'd0);
      check("t2_valid", 32'(a_valid), 32'd1);
      check("t2_ir_held", a_ir, exp_q[0] | 32'hA000_0000);
      ir_ready = 1'b1;
      p0 = pops;
      repeat (8) cycle();
      check("t2_resume", 32'(pops - p0 >= 3), 32'd1);

      // 3: redirect with a full FIFO
      ir_ready = 1'b0;
      repeat (8) cycle();
      check("t3_full_idle", 32'(a_req), 32'd0);
      br_taken = 1'b1;
      br_target = 32'h100;
      cycle();
      load_exp(32'h100);
      check("t3_flush", 32'(a_valid), 32'd0);
      ir_ready = 1'b1;
      ack_delay = 3;
      wait_req("t3_req", 1'b1);
      check("t3_addr", a_addr, 32'h100);

      // 4: redirect while a request is outstanding; last target wins
      br_taken = 1'b1;
      br_target = 32'h203;
      cycle();
      check("t4_drain", 32'(a_state), 32'(DRAIN));
      check("t4_req_hold", 32'(a_req), 32'd1);
      check("t4_addr_hold", a_addr, 32'h100);
      br_taken = 1'b1;
      br_target = 32'h244;
      cycle();
      check("t4_addr_hold2", a_addr, 32'h100);
      cycle();
      n_drop++;
      check("t4_back_fetch", 32'(a_state), 32'(FETCH));
      check("t4_dropped", 32'(a_valid), 32'd0);
      load_exp(32'h244);
      wait_req("t4_req", 1'b1);
      check("t4_addr", a_addr, 32'h244);

      // 5: redirect in the same cycle as the ack
      cycle();
      cycle();
      br_taken = 1'b1;
      br_target = 32'h400;
      cycle();
      n_drop++;
      load_exp(32'h400);
      check("t5_state", 32'(a_state), 32'(FETCH));
      check("t5_req_gap", 32'(a_req), 32'd0);
      check("t5_dropped", 32'(a_valid), 32'd0);
      ack_delay = 1;
      wait_req("t5_req", 1'b1);
      check("t5_addr", a_addr, 32'h400);
      p0 = pops;
      repeat (10) cycle();
      check("t5_pops", 32'(pops - p0 >= 3), 32'd1);

      // 6: async reset in the middle of a drain
      ack_delay = 3;
      wait_req("t6_idle", 1'b0);
      wait_req("t6_req", 1'b1);
      br_taken = 1'b1;
      br_target = 32'h500;
      cycle();
      load_exp(32'h500);
      check("t6_drain", 32'(a_state), 32'(DRAIN));
`ifdef FETCH_PERF_CNT_EN
      check("t6_fetch_cnt", a_fetch_cnt, 32'(n_acks - n_drop));
      check("t6_flush_cnt", a_flush_cnt, 32'(n_br));
`endif
      #2;
      rst = 1'b1;
      imem_ack = 1'b0;
      #1;
      check("t6_rst_req", 32'(a_req), 32'd0);
      check("t6_rst_valid", 32'(a_valid), 32'd0);
      check("t6_rst_state", 32'(a_state), 32'(FETCH));
      check("t6_rst_addr", a_addr, 32'h0);
      check("t6_rst_ir", a_ir, 32'h0);
      check("t6_rst_npc", a_npc, 32'h0);
      check("t6_rst_b_addr", b_addr, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_CNT_EN
      check("t6_rst_fetch_cnt", a_fetch_cnt, 32'd0);
      check("t6_rst_flush_cnt", a_flush_cnt, 32'd0);
`endif
      wait_cnt = 0;
      ack_delay = 1;
      load_exp(32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      wait_req("t6_restart", 1'b1);
      check("t6_addr0", a_addr, 32'h0);
      check("t6_b_req", 32'(b_req), 32'd1);
      check("t6_b_addr0", b_addr, 32'hFFFF_FFFC);
      cycle();
      check("t6_b_valid", 32'(b_valid), 32'd1);
      check("t6_b_ir", b_ir, 32'hA000_0000);
      check("t6_b_npc_wrap", b_npc, 32'h0);
      check("t6_b_opcode", 32'(b_opcode), 32'h28);
      check("t6_b_func", 32'(b_func), 32'h0);
      check("t6_b_state", 32'(b_state), 32'(FETCH));
      wait_req("t6_req1", 1'b1);
      check("t6_addr1", a_addr, 32'h4);
      check("t6_b_addr_wrap", b_addr, 32'h0);
      cycle();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
